// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write forwarding and a per-register
// pending-write scoreboard that the issue stage uses for hazard stalls.
module regfile_mp_sb #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    r_clk,
  input  logic                    r_rst,
  input  logic [NRD*AWIDTH-1:0]   r_rd_addr,
  output logic [NRD*DWIDTH-1:0]   r_rd_data,
  output logic [NRD-1:0]          r_rd_busy,
  input  logic [NWR-1:0]          r_wr_en,
  input  logic [NWR*AWIDTH-1:0]   r_wr_addr,
  input  logic [NWR*DWIDTH-1:0]   r_wr_data,
  input  logic                    r_alloc_en,
  input  logic [AWIDTH-1:0]       r_alloc_addr,
  input  logic                    r_flush,
  output logic [(1<<AWIDTH)-1:0]  r_busy_vec
);

  localparam int   DEPTH    = 1 << AWIDTH;
  localparam logic HAS_ZERO = (ZERO_REG != 0);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [DEPTH-1:0]  wr_hit;
  logic [DWIDTH-1:0] wr_val [DEPTH];
  logic [NWR-1:0]    wr_eff;
  logic              alloc_eff;
  logic [AWIDTH-1:0] ra;
  logic [NRD*DWIDTH-1:0] rd_data_d;
  logic [NRD-1:0]        rd_busy_d;

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wr_eff[w] = r_wr_en[w] && !(HAS_ZERO && (r_wr_addr[w*AWIDTH +: AWIDTH] == '0));
    end
    alloc_eff = r_alloc_en && !(HAS_ZERO && (r_alloc_addr == '0));
  end

  // Ports are scanned in ascending order so the highest-index writer wins.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wr_val[r] = '0;
      for (int w = 0; w < NWR; w++) begin
        if (wr_eff[w] && (r_wr_addr[w*AWIDTH +: AWIDTH] == AWIDTH'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = r_wr_data[w*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  // A new producer outranks a completing write to the same register.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      if (r_flush)
        pend_d[r] = 1'b0;
      else if (alloc_eff && (r_alloc_addr == AWIDTH'(r)))
        pend_d[r] = 1'b1;
      else if (wr_hit[r])
        pend_d[r] = 1'b0;
      else
        pend_d[r] = pend_q[r];
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    ra        = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = r_rd_addr[i*AWIDTH +: AWIDTH];
      if (HAS_ZERO && (ra == '0))
        rd_data_d[i*DWIDTH +: DWIDTH] = '0;
      else if (wr_hit[ra])
        rd_data_d[i*DWIDTH +: DWIDTH] = wr_val[ra];
      else
        rd_data_d[i*DWIDTH +: DWIDTH] = mem_q[ra];
      rd_busy_d[i] = pend_d[ra];
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      pend_q    <= '0;
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) mem_q[r] <= wr_val[r];
      end
      pend_q    <= pend_d;
      r_rd_data <= rd_data_d;
      r_rd_busy <= rd_busy_d;
    end
  end

  assign r_busy_vec = pend_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed vector table, zero-register variant,
// asynchronous reset check and randomized traffic against an array model.
module tb_regfile_mp_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // clock / reset
  logic r_clk = 1'b0;
  logic r_rst = 1'b0;
  always #5 r_clk = ~r_clk;

  // main instance: 2 read, 2 write, hardwired zero register
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            flush;
  logic [DEPTH-1:0] busy_vec;

  // second instance: ordinary register 0, single write port
  logic [2*AW-1:0] z_rd_addr;
  logic [2*DW-1:0] z_rd_data;
  logic [1:0]      z_rd_busy;
  logic [0:0]      z_wr_en;
  logic [AW-1:0]   z_wr_addr;
  logic [DW-1:0]   z_wr_data;
  logic            z_alloc_en;
  logic [AW-1:0]   z_alloc_addr;
  logic            z_flush;
  logic [DEPTH-1:0] z_busy_vec;

  regfile_mp_sb #(.DWIDTH(DW), .AWIDTH(AW), .NRD(2), .NWR(2), .ZERO_REG(1)) u_dut (
    .r_clk(r_clk), .r_rst(r_rst),
    .r_rd_addr(rd_addr), .r_rd_data(rd_data), .r_rd_busy(rd_busy),
    .r_wr_en(wr_en), .r_wr_addr(wr_addr), .r_wr_data(wr_data),
    .r_alloc_en(alloc_en), .r_alloc_addr(alloc_addr),
    .r_flush(flush), .r_busy_vec(busy_vec)
  );

  regfile_mp_sb #(.DWIDTH(DW), .AWIDTH(AW), .NRD(2), .NWR(1), .ZERO_REG(0)) u_dut_z0 (
    .r_clk(r_clk), .r_rst(r_rst),
    .r_rd_addr(z_rd_addr), .r_rd_data(z_rd_data), .r_rd_busy(z_rd_busy),
    .r_wr_en(z_wr_en), .r_wr_addr(z_wr_addr), .r_wr_data(z_wr_data),
    .r_alloc_en(z_alloc_en), .r_alloc_addr(z_alloc_addr),
    .r_flush(z_flush), .r_busy_vec(z_busy_vec)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  logic [DW-1:0] m_mem  [DEPTH];
  logic          m_pend [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1, input logic ae,
                       input logic [4:0] aa, input logic fl, input logic [4:0] ra0,
                       input logic [4:0] ra1);
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    alloc_en   = ae;
    alloc_addr = aa;
    flush      = fl;
    rd_addr    = {ra1, ra0};
  endtask

  task automatic z_idle();
    z_wr_en = '0; z_wr_addr = '0; z_wr_data = '0;
    z_alloc_en = 1'b0; z_alloc_addr = '0; z_flush = 1'b0; z_rd_addr = '0;
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_mem[r]  = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  // Reference: apply one cycle of the rules to the arrays, queue expected reads.
  task automatic model_step(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                            input logic [4:0] wa1, input logic [31:0] wd1, input logic ae,
                            input logic [4:0] aa, input logic fl, input logic [4:0] ra0,
                            input logic [4:0] ra1, output logic [1:0] eb,
                            output logic [31:0] ev);
    logic          hit [DEPTH];
    logic [31:0]   val [DEPTH];
    logic          np  [DEPTH];
    logic [4:0]    wa  [2];
    logic [31:0]   wd  [2];
    logic [4:0]    ra  [2];
    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
    for (int r = 0; r < DEPTH; r++) begin
      hit[r] = 1'b0;
      val[r] = '0;
    end
    for (int w = 0; w < 2; w++) begin
      if (we[w] && wa[w] != 0) begin
        hit[wa[w]] = 1'b1;
        val[wa[w]] = wd[w];
      end
    end
    for (int r = 0; r < DEPTH; r++) begin
      if (fl) np[r] = 1'b0;
      else if (ae && aa != 0 && int'(aa) == r) np[r] = 1'b1;
      else if (hit[r]) np[r] = 1'b0;
      else np[r] = m_pend[r];
    end
    for (int i = 0; i < 2; i++) begin
      if (ra[i] == 0) exp_q.push_back('0);
      else if (hit[ra[i]]) exp_q.push_back(val[ra[i]]);
      else exp_q.push_back(m_mem[ra[i]]);
      eb[i] = np[ra[i]];
    end
    for (int r = 0; r < DEPTH; r++) begin
      if (hit[r]) m_mem[r] = val[r];
      m_pend[r] = np[r];
      ev[r] = np[r];
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ae;
    logic [4:0]  aa;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic [31:0] vec;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  eb;
    logic [31:0] ev;
    logic [1:0]  rwe;
    logic [4:0]  rwa0, rwa1, raa, rra0, rra1;
    logic [31:0] rwd0, rwd1;
    logic        rae, rfl;

    //                we     wa0    wd0           wa1    wd1           ae    aa     fl    ra0    ra1    d0            d1            b      vec
    tbl[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
    tbl[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0};
    tbl[2]  = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       1'b0, 5'd0,  1'b0, 5'd5,  5'd7,  32'hDEADBEEF, 32'h22,       2'b00, 32'h0};
    tbl[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  32'h22,       32'h22,       2'b00, 32'h0};
    tbl[4]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd5,  32'h0,        32'hDEADBEEF, 2'b01, 32'h8};
    tbl[5]  = '{2'b01, 5'd3,  32'h33,       5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd3,  32'h33,       32'h33,       2'b11, 32'h8};
    tbl[6]  = '{2'b10, 5'd0,  32'h0,        5'd3,  32'h44,       1'b0, 5'd0,  1'b0, 5'd3,  5'd0,  32'h44,       32'h0,        2'b00, 32'h0};
    tbl[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 5'd1,  5'd7,  32'h0,        32'h22,       2'b01, 32'h2};
    tbl[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd2,  5'd1,  32'h0,        32'h0,        2'b11, 32'h6};
    tbl[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd2,  32'h0,        32'h0,        2'b11, 32'h206};
    tbl[10] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd4,  1'b1, 5'd4,  5'd9,  32'h0,        32'h0,        2'b00, 32'h0};
    tbl[11] = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
    tbl[12] = '{2'b10, 5'd0,  32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0};
    tbl[13] = '{2'b01, 5'd10, 32'hA5A5A5A5, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd10, 5'd3,  32'hA5A5A5A5, 32'h44,       2'b00, 32'h0};
    tbl[14] = '{2'b11, 5'd10, 32'h1,        5'd10, 32'h2,        1'b1, 5'd10, 1'b0, 5'd10, 5'd4,  32'h2,        32'h0,        2'b01, 32'h400};

    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    z_idle();
    repeat (2) @(posedge r_clk);
    #1;
    check("reset rd_data", rd_data, 64'h0);
    check("reset busy_vec", {32'h0, busy_vec}, 64'h0);
    @(negedge r_clk);
    r_rst = 1'b1;

    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].we, tbl[k].wa0, tbl[k].wd0, tbl[k].wa1, tbl[k].wd1, tbl[k].ae,
            tbl[k].aa, tbl[k].fl, tbl[k].ra0, tbl[k].ra1);
      tick();
      check($sformatf("row%0d d0", k), {32'h0, rd_data[31:0]}, {32'h0, tbl[k].d0});
      check($sformatf("row%0d d1", k), {32'h0, rd_data[63:32]}, {32'h0, tbl[k].d1});
      check($sformatf("row%0d busy", k), {62'h0, rd_busy}, {62'h0, tbl[k].b});
      check($sformatf("row%0d vec", k), {32'h0, busy_vec}, {32'h0, tbl[k].vec});
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

    // register 0 behaves as an ordinary register in the second instance
    z_wr_en = 1'b1; z_wr_addr = 5'd0; z_wr_data = 32'hFFFFFFFF;
    z_alloc_en = 1'b1; z_alloc_addr = 5'd0; z_rd_addr = '0;
    tick();
    check("z0 fwd d0", {32'h0, z_rd_data[31:0]}, 64'hFFFFFFFF);
    check("z0 fwd d1", {32'h0, z_rd_data[63:32]}, 64'hFFFFFFFF);
    check("z0 fwd busy", {62'h0, z_rd_busy}, 64'h3);
    check("z0 vec", {32'h0, z_busy_vec}, 64'h1);
    z_idle();
    tick();
    check("z0 stored d0", {32'h0, z_rd_data[31:0]}, 64'hFFFFFFFF);
    check("z0 held vec", {32'h0, z_busy_vec}, 64'h1);

    // asynchronous reset mid-cycle with traffic in flight
    drive(2'b11, 5'd6, 32'h12345678, 5'd10, 32'h9, 1'b1, 5'd6, 1'b0, 5'd10, 5'd6);
    #2;
    r_rst = 1'b0;
    #1;
    check("async rd_data", rd_data, 64'h0);
    check("async rd_busy", {62'h0, rd_busy}, 64'h0);
    check("async busy_vec", {32'h0, busy_vec}, 64'h0);
    check("async z rd_data", z_rd_data, 64'h0);
    check("async z busy_vec", {32'h0, z_busy_vec}, 64'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd5);
    @(posedge r_clk);
    @(negedge r_clk);
    r_rst = 1'b1;
    tick();
    check("post reset reg10", {32'h0, rd_data[31:0]}, 64'h0);
    check("post reset reg5", {32'h0, rd_data[63:32]}, 64'h0);
    check("post reset vec", {32'h0, busy_vec}, 64'h0);

    // randomized traffic against the array model
    model_reset();
    for (int n = 0; n < 400; n++) begin
      rwe  = 2'($urandom_range(0, 3));
      rwa0 = 5'($urandom_range(0, 7));
      rwa1 = 5'($urandom_range(0, 7));
      rwd0 = $urandom;
      rwd1 = $urandom;
      rae  = 1'($urandom_range(0, 1));
      raa  = 5'($urandom_range(0, 7));
      rfl  = ($urandom_range(0, 15) == 0);
      rra0 = 5'($urandom_range(0, 7));
      rra1 = 5'($urandom_range(0, 7));
      model_step(rwe, rwa0, rwd0, rwa1, rwd1, rae, raa, rfl, rra0, rra1, eb, ev);
      drive(rwe, rwa0, rwd0, rwa1, rwd1, rae, raa, rfl, rra0, rra1);
      tick();
      check("rand d0", {32'h0, rd_data[31:0]}, {32'h0, exp_q.pop_front()});
      check("rand d1", {32'h0, rd_data[63:32]}, {32'h0, exp_q.pop_front()});
      check("rand busy", {62'h0, rd_busy}, {62'h0, eb});
      check("rand vec", {32'h0, busy_vec}, {32'h0, ev});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
